register_file_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 18 +
 rtl/register_file_mp_scoreboard.sv | 61 ++++++
 rtl/register_file_mp.sv | 89 ++++++++
 tb/tb_register_file_mp.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, address type and packed-port slicing helper for the
// multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_N_RD   = 2;

  // Register index at the default address width.
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  // LSB position of field k inside a vector of equal-width fields packed
  // with port 0 in the lowest bits.
  function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy scoreboard: reserve sets, write clears, reserve wins on
// a same-address collision. Exposes per-port busy lookup and any_busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = DEF_N_RD,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   resv_en,
  input  logic [ADDR_W-1:0]      resv_addr,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]        rd_busy_raw,
  output logic                   any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
    logic set_hit;
    logic clr_hit;

    // Register 0 never goes busy when it is hard-wired to zero.
    assign set_hit = resv_en && (resv_addr == ADDR_W'(gi)) &&
                     !((ZERO_REG != 0) && (gi == 0));
    assign clr_hit = wr_en && (wr_addr == ADDR_W'(gi));

    // Reservation belongs to a newer instruction than the write, so set beats clear.
    always_comb begin
      busy_next[gi] = busy_reg[gi];
      if (set_hit) begin
        busy_next[gi] = 1'b1;
      end else if (clr_hit) begin
        busy_next[gi] = 1'b0;
      end
    end
  end

  // Busy vector state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign any_busy = |busy_reg;

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_port
    assign rd_busy_raw[gi] = busy_reg[rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W]];
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with asynchronous clear, optional
// hard-wired zero register, write-to-read bypass and busy scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = DEF_N_RD,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   resv_en,
  input  logic [ADDR_W-1:0]      resv_addr,
  output logic                   any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              wr_accept;
  logic [N_RD-1:0]   rd_busy_raw;

  // Writes to the zero register are dropped so it keeps reading 0.
  assign wr_accept = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Data array: whole array cleared on reset, one write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_accept) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .resv_en     (resv_en),
    .resv_addr   (resv_addr),
    .rd_addr     (rd_addr),
    .rd_busy_raw (rd_busy_raw),
    .any_busy    (any_busy)
  );

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zero_hit;
    logic              byp_hit;
    logic [DATA_W-1:0] port_data;
    logic              port_busy;

    assign addr     = rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);
    assign byp_hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);

    // Read mux: zero register first, then same-cycle write, then stored state.
    always_comb begin
      port_data = mem_reg[addr];
      port_busy = rd_busy_raw[gi];
      if (zero_hit) begin
        port_data = '0;
        port_busy = 1'b0;
      end else if (byp_hit) begin
        port_data = wr_data;
        port_busy = 1'b0;
      end
    end

    assign rd_data[port_lsb(gi, DATA_W) +: DATA_W] = port_data;
    assign rd_busy[gi] = port_busy;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default build, a BYPASS=0 build on
// the same stimulus, and a ZERO_REG=1 / N_RD=4 / DATA_W=32 build.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default build (and its BYPASS=0 twin on shared inputs)
  logic [7:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        resv_en = 1'b0;
  logic [3:0]  resv_addr = '0;
  logic        any_busy;
  logic [31:0] nb_rd_data;
  logic [1:0]  nb_rd_busy;
  logic        nb_any_busy;

  // Wide zero-register build
  logic [15:0]  z_rd_addr = '0;
  logic [127:0] z_rd_data;
  logic [3:0]   z_rd_busy;
  logic         z_wr_en = 1'b0;
  logic [3:0]   z_wr_addr = '0;
  logic [31:0]  z_wr_data = '0;
  logic         z_resv_en = 1'b0;
  logic [3:0]   z_resv_addr = '0;
  logic         z_any_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file_mp dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr), .any_busy(any_busy)
  );

  register_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .rd_busy(nb_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr), .any_busy(nb_any_busy)
  );

  register_file_mp #(.DATA_W(32), .N_RD(4), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .rd_addr(z_rd_addr), .rd_data(z_rd_data),
    .rd_busy(z_rd_busy), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .resv_en(z_resv_en), .resv_addr(z_resv_addr), .any_busy(z_any_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        resv_en;
    logic [3:0]  resv_addr;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [15:0] exp_d0;
    logic [15:0] exp_d1;
    logic [1:0]  exp_busy;
    logic        exp_any;
    logic [15:0] exp_nb_d0;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // wr_en addr data   resv addr  ra0 ra1  d0       d1       busy  any nb_d0
    vecs[0]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd3, 4'd7, 16'h1234, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 4'd7, 16'hA5A5, 1'b0, 4'd0, 4'd3, 4'd7, 16'h1234, 16'hA5A5, 2'b00, 1'b0, 16'h1234};
    vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd7, 16'h1234, 16'hA5A5, 2'b00, 1'b0, 16'h1234};
    vecs[3]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3, 16'h1234, 16'h1234, 2'b00, 1'b0, 16'h1234};
    vecs[4]  = '{1'b1, 4'd9, 16'h0F0F, 1'b0, 4'd0, 4'd9, 4'd3, 16'h0F0F, 16'h1234, 2'b00, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 4'd9, 4'd9, 16'h0F0F, 16'h0F0F, 2'b00, 1'b0, 16'h0F0F};
    vecs[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd9, 16'h0000, 16'h0F0F, 2'b01, 1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 4'd4, 16'h0042, 1'b0, 4'd0, 4'd4, 4'd4, 16'h0042, 16'h0042, 2'b00, 1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd4, 4'd4, 16'h0042, 16'h0042, 2'b00, 1'b0, 16'h0042};
    vecs[9]  = '{1'b1, 4'd2, 16'h7777, 1'b1, 4'd2, 4'd2, 4'd5, 16'h7777, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd2, 4'd2, 16'h7777, 16'h7777, 2'b11, 1'b1, 16'h7777};
    vecs[11] = '{1'b1, 4'd2, 16'h1111, 1'b0, 4'd0, 4'd2, 4'd0, 16'h1111, 16'h0000, 2'b00, 1'b1, 16'h7777};
    vecs[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd2, 4'd2, 16'h1111, 16'h1111, 2'b00, 1'b0, 16'h1111};

    // Reset state
    #2;
    rd_addr = {4'd7, 4'd3};
    #1;
    chk("reset_d0", 64'(rd_data[15:0]), 64'h0);
    chk("reset_busy", 64'(rd_busy), 64'h0);
    chk("reset_any", 64'(any_busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write r5, reserve r6, then pulse reset between edges
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    resv_en = 1'b1; resv_addr = 4'd6;
    @(negedge clk);
    wr_en = 1'b0; resv_en = 1'b0;
    rd_addr = {4'd6, 4'd5};
    #1;
    chk("pre_rst_r5", 64'(rd_data[15:0]), 64'hBEEF);
    chk("pre_rst_any", 64'(any_busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_r5", 64'(rd_data[15:0]), 64'h0);
    chk("async_rst_busy", 64'(rd_busy), 64'h0);
    chk("async_rst_any", 64'(any_busy), 64'h0);
    $display("txn reset_pulse r5=0x%0h any_busy=%0d", rd_data[15:0], any_busy);

    // Write held across an edge while reset is low must not land
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_mid_write_r5", 64'(rd_data[15:0]), 64'h0);

    // Table-driven main sequence
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      resv_en = vecs[i].resv_en; resv_addr = vecs[i].resv_addr;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #2;
      $display("txn %0d wr=%0d a=%0d d=0x%0h resv=%0d a=%0d ra=%0d/%0d -> d0=0x%0h d1=0x%0h busy=%b any=%0d nb_d0=0x%0h",
               i, wr_en, wr_addr, wr_data, resv_en, resv_addr, vecs[i].ra0, vecs[i].ra1,
               rd_data[15:0], rd_data[31:16], rd_busy, any_busy, nb_rd_data[15:0]);
      chk($sformatf("v%0d_d0", i), 64'(rd_data[15:0]), 64'(vecs[i].exp_d0));
      chk($sformatf("v%0d_d1", i), 64'(rd_data[31:16]), 64'(vecs[i].exp_d1));
      chk($sformatf("v%0d_busy", i), 64'(rd_busy), 64'(vecs[i].exp_busy));
      chk($sformatf("v%0d_any", i), 64'(any_busy), 64'(vecs[i].exp_any));
      chk($sformatf("v%0d_nb_d0", i), 64'(nb_rd_data[15:0]), 64'(vecs[i].exp_nb_d0));
    end
    @(negedge clk);
    wr_en = 1'b0; resv_en = 1'b0;

    // Zero-register build: write and reserve r0 together
    z_rd_addr = {4'd0, 4'd0, 4'd0, 4'd0};
    z_wr_en = 1'b1; z_wr_addr = 4'd0; z_wr_data = 32'hFFFF_FFFF;
    z_resv_en = 1'b1; z_resv_addr = 4'd0;
    #2;
    chk("z_r0_same_cycle", 64'(z_rd_data[31:0]), 64'h0);
    @(negedge clk);
    z_wr_en = 1'b0; z_resv_en = 1'b0;
    #2;
    $display("txn z_r0 d=0x%0h busy=%b any=%0d", z_rd_data[31:0], z_rd_busy, z_any_busy);
    chk("z_r0_data", 64'(z_rd_data[31:0]), 64'h0);
    chk("z_r0_busy", 64'(z_rd_busy), 64'h0);
    chk("z_r0_any", 64'(z_any_busy), 64'h0);

    // Wide build write/read on four ports, plus a reservation of r1
    @(negedge clk);
    z_wr_en = 1'b1; z_wr_addr = 4'd3; z_wr_data = 32'h1234_5678;
    @(negedge clk);
    z_wr_addr = 4'd7; z_wr_data = 32'hA5A5_A5A5;
    z_resv_en = 1'b1; z_resv_addr = 4'd1;
    @(negedge clk);
    z_wr_en = 1'b0; z_resv_en = 1'b0;
    z_rd_addr = {4'd1, 4'd3, 4'd7, 4'd3};
    #2;
    $display("txn z_rd p0=0x%0h p1=0x%0h p2=0x%0h p3=0x%0h busy=%b any=%0d",
             z_rd_data[31:0], z_rd_data[63:32], z_rd_data[95:64], z_rd_data[127:96],
             z_rd_busy, z_any_busy);
    chk("z_p0", 64'(z_rd_data[31:0]), 64'h1234_5678);
    chk("z_p1", 64'(z_rd_data[63:32]), 64'hA5A5_A5A5);
    chk("z_p2", 64'(z_rd_data[95:64]), 64'h1234_5678);
    chk("z_p3", 64'(z_rd_data[127:96]), 64'h0);
    chk("z_busy", 64'(z_rd_busy), 64'b1000);
    chk("z_any", 64'(z_any_busy), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
